// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between IF fetch and MEM load/store, with fixed MEM priority.
// Optional stall cycle counter enabled by defining STALL_CNT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e     state_q;
    logic       owner_mem_q;
    logic [3:0] cnt_q;
    logic       mem_req;

    assign mem_req = mem_rd_en | mem_wr_en;

    // ram_we doubles as the latched write flag for the transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            cnt_q       <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (mem_req) begin
                        owner_mem_q <= 1'b1;
                        ram_addr    <= mem_addr;
                        ram_wdata   <= mem_wdata;
                        ram_we      <= mem_wr_en;
                        ram_en      <= 1'b1;
                        cnt_q       <= CntInit;
                        state_q     <= StAccess;
                    end else if (if_req) begin
                        owner_mem_q <= 1'b0;
                        ram_addr    <= if_addr;
                        ram_we      <= 1'b0;
                        ram_en      <= 1'b1;
                        cnt_q       <= CntInit;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (!ram_we) begin
                            if (owner_mem_q) begin
                                mem_rdata <= ram_rdata;
                            end else begin
                                if_rdata <= ram_rdata;
                            end
                        end
                        if (owner_mem_q) begin
                            mem_ready <= 1'b1;
                        end else begin
                            if_ready <= 1'b1;
                        end
                        ram_en  <= 1'b0;
                        ram_we  <= 1'b0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // Requests still high here belong to the transaction just completed.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic stall;

    assign stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
